axi_write_burst: RTL and testbench

Parametrised AXI4 write master that drains an AXI-Stream-style input into a circular memory region as fixed-length INCR bursts. It is the successor to the single-mode stream-to-AXI writer: the burst length, base address and region size are parameters, and the address wraps inside the region. Bursts cut short by `s_wr_tlast` are padded with null-strobe beats, and the write response is checked. It sits between a capture/packet source and the memory interconnect, in a single clock domain.

---
 rtl/axi_write_burst.sv | 215 +++++++++++++++++++++
 tb/tb_axi_write_burst.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_burst.sv
`default_nettype none
// ============================================================================
// Module   : axi_write_burst
// Purpose  : AXI4 write master that drains a stream into a circular memory
//            region as fixed-length INCR bursts. Frames ending mid-burst are
//            padded with null-strobe beats; write responses are checked.
// Ports    : aclk, areset            - clock, async active-high reset
//            s_wr_t*                 - input stream (data/valid/last/ready)
//            m_axi_aw*               - AXI4 write address channel
//            m_axi_w*                - AXI4 write data channel
//            m_axi_b*                - AXI4 write response channel
//            frame_done              - pulse: burst holding a tlast was acked
//            wr_err                  - sticky: a non-OKAY response was seen
//            busy                    - FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module axi_write_burst #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    BURST_LEN    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = 'h0100_0000
) (
    input  logic                    aclk,
    input  logic                    areset,
    // Input stream
    input  logic [DATA_WIDTH-1:0]   s_wr_tdata,
    input  logic                    s_wr_tvalid,
    input  logic                    s_wr_tlast,
    output logic                    s_wr_tready,
    // AW channel
    output logic                    m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // W channel
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // B channel
    input  logic                    m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // Status
    output logic                    frame_done,
    output logic                    wr_err,
    output logic                    busy
);

    localparam int                    c_STRB_W      = DATA_WIDTH / 8;
    localparam int                    c_CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_CNT_W-1:0]    c_LAST_BEAT   = c_CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] c_BURST_BYTES = ADDR_WIDTH'(BURST_LEN * c_STRB_W);
    // Wraps naturally at ADDR_WIDTH when the region ends at the top of memory,
    // matching the equally truncated pointer increment.
    localparam logic [ADDR_WIDTH-1:0] c_REGION_END  = BASE_ADDR + REGION_BYTES;
    localparam logic [7:0]            c_AWLEN       = 8'(BURST_LEN - 1);
    localparam logic [2:0]            c_AWSIZE      = 3'($clog2(c_STRB_W));

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_CNT_W-1:0]    r_beat_cnt;
    logic                  r_pad;
    logic                  r_frame_in_burst;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_frame_done;
    logic                  r_wr_err;

    logic                  w_is_last;
    logic                  w_w_fire;
    logic                  w_in_fire;
    logic                  w_b_fire;
    logic [ADDR_WIDTH-1:0] w_ptr_inc;
    logic                  w_unused;

    // The single outstanding burst makes the response ID irrelevant.
    assign w_unused = m_axi_bid;

    assign w_is_last = (r_beat_cnt == c_LAST_BEAT);
    assign w_w_fire  = m_axi_wvalid & m_axi_wready;
    assign w_in_fire = s_wr_tvalid & s_wr_tready;
    assign w_b_fire  = (r_state == c_ST_RESP) & m_axi_bvalid;
    assign w_ptr_inc = r_ptr + c_BURST_BYTES;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (s_wr_tvalid)             w_state_next = c_ST_ADDR;
            c_ST_ADDR: if (m_axi_awready)           w_state_next = c_ST_DATA;
            c_ST_DATA: if (w_w_fire && w_is_last)   w_state_next = c_ST_RESP;
            c_ST_RESP: if (m_axi_bvalid)            w_state_next = c_ST_IDLE;
            default:                                w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The W channel is a combinational pass-through of the
    // stream; pad beats are self-generated and do not consume input.
    // ------------------------------------------------------------------
    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_bready  = 1'b0;
        s_wr_tready   = 1'b0;
        case (r_state)
            c_ST_ADDR: m_axi_awvalid = 1'b1;
            c_ST_DATA: begin
                m_axi_wvalid = r_pad | s_wr_tvalid;
                s_wr_tready  = m_axi_wready & ~r_pad;
                m_axi_wdata  = r_pad ? '0 : s_wr_tdata;
                m_axi_wstrb  = r_pad ? '0 : '1;
                m_axi_wlast  = w_is_last;
            end
            c_ST_RESP: m_axi_bready = 1'b1;
            default: ;
        endcase
    end

    assign busy = (r_state != c_ST_IDLE);

    // ------------------------------------------------------------------
    // Beat counter, padding and frame tracking
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_beat_cnt       <= '0;
            r_pad            <= 1'b0;
            r_frame_in_burst <= 1'b0;
        end else begin
            if ((r_state == c_ST_DATA) && w_w_fire) begin
                if (w_is_last) begin
                    r_beat_cnt <= '0;
                    r_pad      <= 1'b0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                    // tlast on a non-final beat: fill the rest with null beats
                    if (w_in_fire && s_wr_tlast) begin
                        r_pad <= 1'b1;
                    end
                end
            end
            if (w_b_fire) begin
                r_frame_in_burst <= 1'b0;
            end else if (w_in_fire && s_wr_tlast) begin
                r_frame_in_burst <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Circular address pointer and response status
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ptr        <= BASE_ADDR;
            r_frame_done <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_frame_done <= w_b_fire & r_frame_in_burst;
            if (w_b_fire) begin
                r_ptr <= (w_ptr_inc == c_REGION_END) ? BASE_ADDR : w_ptr_inc;
                if (m_axi_bresp != 2'b00) begin
                    r_wr_err <= 1'b1;
                end
            end
        end
    end

    assign frame_done    = r_frame_done;
    assign wr_err        = r_wr_err;

    assign m_axi_awaddr  = r_ptr;
    assign m_axi_awid    = 1'b0;
    assign m_axi_awlen   = c_AWLEN;
    assign m_axi_awsize  = c_AWSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_axi_write_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_write_burst
// Purpose  : Scoreboard bench for axi_write_burst (64-bit, 4-beat bursts,
//            256-byte region). Stimulus pushes expected AW/W/B-side results
//            into queues; a negedge monitor pops and compares on handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_write_burst;

    localparam int          DW   = 64;
    localparam int          BL   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic          aclk;
    logic          areset;
    logic [DW-1:0] s_wr_tdata;
    logic          s_wr_tvalid;
    logic          s_wr_tlast;
    logic          s_wr_tready;
    logic          m_axi_awid;
    logic [31:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awlock;
    logic [3:0]    m_axi_awcache;
    logic [2:0]    m_axi_awprot;
    logic [3:0]    m_axi_awqos;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [7:0]    m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic          m_axi_bid;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic          frame_done;
    logic          wr_err;
    logic          busy;

    axi_write_burst #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (DW),
        .BURST_LEN    (BL),
        .BASE_ADDR    (BASE),
        .REGION_BYTES (32'h0000_0100)
    ) u_dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_wr_tdata    (s_wr_tdata),
        .s_wr_tvalid   (s_wr_tvalid),
        .s_wr_tlast    (s_wr_tlast),
        .s_wr_tready   (s_wr_tready),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awlock  (m_axi_awlock),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awqos   (m_axi_awqos),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .frame_done    (frame_done),
        .wr_err        (wr_err),
        .busy          (busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [7:0]    s;
        logic          l;
        logic          t;
    } wbeat_t;

    logic [31:0] q_aw[$];
    wbeat_t      q_w[$];
    bit          q_fd[$];

    int checks   = 0;
    int failures = 0;

    bit bp_mode   = 0;
    bit abort     = 0;
    int w_hs_cnt  = 0;
    int b_pending = 0;
    int b_delay   = 0;
    int b_count   = 0;
    int err_burst = -1;
    bit b_hs      = 0;
    bit model_err = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected W beats for one frame: real beats, then null beats up to the
    // next burst boundary. Every frame starts on a fresh burst.
    task automatic push_frame(input int len, input logic [63:0] base);
        wbeat_t e;
        int     nb;
        int     i;
        nb = (len + BL - 1) / BL;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < BL; k++) begin
                i   = b * BL + k;
                e.l = (k == BL - 1);
                if (i < len) begin
                    e.d = base + 64'(i);
                    e.s = 8'hFF;
                    e.t = 1'b1;
                end else begin
                    e.d = '0;
                    e.s = '0;
                    e.t = 1'b0;
                end
                q_w.push_back(e);
            end
            q_fd.push_back(b == nb - 1);
        end
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic send_frame(input int len, input logic [63:0] base);
        bit hs;
        int n;
        for (int i = 0; i < len; i++) begin
            if (bp_mode) begin
                repeat ($urandom_range(0, 2)) begin
                    s_wr_tvalid = 1'b0;
                    @(posedge aclk); #1;
                end
            end
            s_wr_tdata  = base + 64'(i);
            s_wr_tlast  = (i == len - 1);
            s_wr_tvalid = 1'b1;
            hs = 0;
            n  = 0;
            while (!hs && !abort) begin
                @(negedge aclk);
                hs = s_wr_tready;
                @(posedge aclk); #1;
                n++;
                if (n > 2000) begin
                    checks++;
                    failures++;
                    $display("FAIL stream_accept: actual=timeout required=tready within 2000 cycles");
                    abort = 1;
                end
            end
            if (abort) break;
        end
        s_wr_tvalid = 1'b0;
        s_wr_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((q_aw.size() != 0 || q_w.size() != 0 || q_fd.size() != 0 || busy || m_axi_bvalid) && n < 3000) begin
            @(posedge aclk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: actual=timeout required=idle with empty scoreboard", name);
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    // Ready generators
    initial begin
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (bp_mode) begin
                m_axi_awready = 1'($urandom_range(0, 1));
                m_axi_wready  = 1'($urandom_range(0, 1));
            end else begin
                m_axi_awready = 1'b1;
                m_axi_wready  = 1'b1;
            end
        end
    end

    // B responder
    initial begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        m_axi_bid    = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (areset) begin
                m_axi_bvalid = 1'b0;
                b_pending    = 0;
                b_hs         = 0;
            end else begin
                if (b_hs) begin
                    m_axi_bvalid = 1'b0;
                    b_hs         = 0;
                    b_pending--;
                    b_count++;
                end
                if (!m_axi_bvalid && b_pending > 0) begin
                    if (b_delay > 0) begin
                        b_delay--;
                    end else begin
                        m_axi_bvalid = 1'b1;
                        m_axi_bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit          aw_wait = 0;
        bit          w_wait  = 0;
        bit          fd_due  = 0;
        bit          err_due = 0;
        logic [31:0] aw_prev;
        wbeat_t      w_prev;
        wbeat_t      e;
        forever begin
            @(negedge aclk);
            if (areset) begin
                aw_wait   = 0;
                w_wait    = 0;
                fd_due    = 0;
                err_due   = 0;
                model_err = 0;
            end else begin
                if (aw_wait) begin
                    check("aw_hold_valid", m_axi_awvalid, 1'b1);
                    check("aw_hold_addr", m_axi_awaddr, aw_prev);
                end
                if (w_wait) begin
                    check("w_hold_valid", m_axi_wvalid, 1'b1);
                    check("w_hold_data", m_axi_wdata, w_prev.d);
                    check("w_hold_strb", m_axi_wstrb, w_prev.s);
                end
                if (fd_due || frame_done) check("frame_done", frame_done, fd_due);
                if (err_due) check("wr_err", wr_err, model_err);
                fd_due  = 0;
                err_due = 0;

                if (m_axi_awvalid && m_axi_awready) begin
                    if (q_aw.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL aw_unexpected: actual awaddr=%0h required=no burst", m_axi_awaddr);
                    end else begin
                        check("awaddr", m_axi_awaddr, q_aw.pop_front());
                    end
                    check("awlen", m_axi_awlen, 8'd3);
                    check("awsize", m_axi_awsize, 3'd3);
                    check("awcache", m_axi_awcache, 4'b0011);
                    check("awburst", m_axi_awburst, 2'b01);
                    check("aw_zero_fields", {m_axi_awid, m_axi_awlock, m_axi_awprot, m_axi_awqos}, 9'd0);
                end

                if (m_axi_wvalid && m_axi_wready) begin
                    w_hs_cnt++;
                    if (q_w.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL w_unexpected: actual wdata=%0h required=no beat", m_axi_wdata);
                    end else begin
                        e = q_w.pop_front();
                        check("wdata", m_axi_wdata, e.d);
                        check("wstrb", m_axi_wstrb, e.s);
                        check("wlast", m_axi_wlast, e.l);
                        check("tready_on_beat", s_wr_tready, e.t);
                    end
                    if (m_axi_wlast) begin
                        b_pending++;
                        b_delay = bp_mode ? int'($urandom_range(0, 10)) : 0;
                    end
                end

                if (m_axi_bvalid && m_axi_bready) begin
                    b_hs    = 1;
                    err_due = 1;
                    if (m_axi_bresp != 2'b00) model_err = 1;
                    if (q_fd.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b_unexpected: actual=bready handshake required=no response pending");
                    end else begin
                        fd_due = q_fd.pop_front();
                    end
                end

                aw_wait = m_axi_awvalid && !m_axi_awready;
                aw_prev = m_axi_awaddr;
                w_wait  = m_axi_wvalid && !m_axi_wready;
                w_prev.d = m_axi_wdata;
                w_prev.s = m_axi_wstrb;
            end
        end
    end

    // Watchdog
    initial begin
        repeat (50000) @(posedge aclk);
        failures++;
        $display("FAIL watchdog: actual=50000 cycles required=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, m_axi_awvalid, 1'b0);
        check({tag, "_wvalid"}, m_axi_wvalid, 1'b0);
        check({tag, "_wlast"}, m_axi_wlast, 1'b0);
        check({tag, "_bready"}, m_axi_bready, 1'b0);
        check({tag, "_tready"}, s_wr_tready, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_wr_err"}, wr_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_awaddr"}, m_axi_awaddr, 32'h1000_0000);
        check({tag, "_wstrb"}, m_axi_wstrb, 8'h00);
    endtask

    initial begin
        int n;
        areset      = 1'b1;
        s_wr_tdata  = '0;
        s_wr_tvalid = 1'b0;
        s_wr_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        areset = 1'b0;
        @(posedge aclk); #1;

        // Single frame, tlast on beat 4, with latency checks
        q_aw.push_back(32'h1000_0000);
        push_frame(4, 64'hA000);
        fork
            send_frame(4, 64'hA000);
            begin
                @(negedge aclk);
                check("lat_idle_awvalid", m_axi_awvalid, 1'b0);
                @(negedge aclk);
                check("lat_addr_awvalid", m_axi_awvalid, 1'b1);
                check("lat_addr_tready", s_wr_tready, 1'b0);
                check("lat_addr_busy", busy, 1'b1);
                @(negedge aclk);
                check("lat_data_wvalid", m_axi_wvalid, 1'b1);
                check("lat_data_tready", s_wr_tready, 1'b1);
                check("lat_data_awvalid", m_axi_awvalid, 1'b0);
            end
        join
        wait_idle("single");

        // Early tlast on beat 2; following frame's first beat must wait
        q_aw.push_back(32'h1000_0020);
        q_aw.push_back(32'h1000_0040);
        push_frame(2, 64'hB000);
        push_frame(4, 64'hB100);
        send_frame(2, 64'hB000);
        send_frame(4, 64'hB100);
        wait_idle("early_tlast");

        // Error response on the second burst of this group, OKAY afterwards
        err_burst = b_count + 1;
        q_aw.push_back(32'h1000_0060);
        q_aw.push_back(32'h1000_0080);
        q_aw.push_back(32'h1000_00A0);
        push_frame(4, 64'hC000);
        push_frame(4, 64'hC100);
        push_frame(4, 64'hC200);
        send_frame(4, 64'hC000);
        send_frame(4, 64'hC100);
        send_frame(4, 64'hC200);
        wait_idle("error");
        check("wr_err_sticky", wr_err, 1'b1);
        err_burst = -1;

        // Reset after the second beat of a burst
        q_aw.push_back(32'h1000_00C0);
        push_frame(4, 64'hD000);
        w_hs_cnt = 0;
        abort    = 0;
        fork
            send_frame(4, 64'hD000);
        join_none
        n = 0;
        while (w_hs_cnt < 2 && n < 200) begin
            @(posedge aclk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL midburst_start: actual=timeout required=two beats");
        end
        @(negedge aclk); #2;
        abort  = 1;
        areset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge aclk);
        #1;
        q_aw.delete();
        q_w.delete();
        q_fd.delete();
        abort  = 0;
        areset = 1'b0;
        @(posedge aclk); #1;

        // Fresh burst at base, then continue through the region wrap
        for (int k = 0; k < 8; k++) q_aw.push_back(BASE + 32'(k) * 32'h20);
        q_aw.push_back(32'h1000_0000);
        push_frame(36, 64'hE000);
        send_frame(36, 64'hE000);
        wait_idle("wrap");

        // Backpressure on every channel
        bp_mode = 1;
        q_aw.push_back(32'h1000_0020);
        q_aw.push_back(32'h1000_0040);
        q_aw.push_back(32'h1000_0060);
        q_aw.push_back(32'h1000_0080);
        q_aw.push_back(32'h1000_00A0);
        push_frame(5, 64'hF000);
        push_frame(3, 64'hF100);
        push_frame(8, 64'hF200);
        send_frame(5, 64'hF000);
        send_frame(3, 64'hF100);
        send_frame(8, 64'hF200);
        wait_idle("backpressure");
        bp_mode = 0;
        check("final_wr_err", wr_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
